pipe_control: RTL and testbench

- Pipelined successor to the single-cycle main decoder for the 5-stage MIPS core.
- Decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and ID-branch data hazards, and generates stall, bubble and flush controls for PC, IF/ID and the pipeline.
- Undefined opcodes decode to a fully deterministic NOP bundle with an illegal flag; no x outputs.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/pipe_control.sv | 127 ++++++++++++
 tb/tb_pipe_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcodes, ALUOp encodings and control bundle for the MIPS control path
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode table, shared with the single-cycle core
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       uses_rt
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Instructions that actually read rt as a source operand
  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined control: decode, ID/EX-EX/MEM-MEM/WB control registers, hazard stall/flush
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter int HAZARD_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               freeze_i,
  input  logic [5:0]         Op_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [REG_W-1:0]   rt_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic               eq_i,
  output logic               pc_write_o,
  output logic               ifid_write_o,
  output logic               flush_o,
  output logic               jump_o,
  output logic               branch_taken_o,
  output logic               illegal_o,
  output logic               ex_RegDst_o,
  output logic               ex_ALUSrc_o,
  output logic [ALUOP_W-1:0] ex_ALUOp_o,
  output logic [REG_W-1:0]   ex_dest_o,
  output logic               ex_RegWrite_o,
  output logic               mem_MemRead_o,
  output logic               mem_MemWrite_o,
  output logic               mem_RegWrite_o,
  output logic [REG_W-1:0]   mem_dest_o,
  output logic               wb_RegWrite_o,
  output logic               wb_MemtoReg_o,
  output logic [REG_W-1:0]   wb_dest_o
);

  ctrl_t            id_ctrl;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;

  ctrl_decode u_decode (
    .op      (Op_i),
    .ctrl    (id_ctrl),
    .illegal (illegal_o),
    .uses_rt (id_uses_rt)
  );

  // A non-writing instruction carries dest 0 so it can never match a hazard compare
  assign id_dest = !id_ctrl.reg_write ? '0 : (id_ctrl.reg_dst ? rd_i : rt_i);

  logic ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic mem_mem_to_reg;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic load_use, branch_hazard, stall, advance;

  assign ex_rs_hit  = (ex_dest_o != '0) && (ex_dest_o == rs_i);
  assign ex_rt_hit  = (ex_dest_o != '0) && (ex_dest_o == rt_i);
  assign mem_rs_hit = (mem_dest_o != '0) && (mem_dest_o == rs_i);
  assign mem_rt_hit = (mem_dest_o != '0) && (mem_dest_o == rt_i);

  assign load_use = ex_mem_read && (ex_rs_hit || (id_uses_rt && ex_rt_hit));

  // beq compares in ID, so it waits for ALU results in EX and load data still in MEM
  assign branch_hazard = id_ctrl.branch &&
                         ((ex_RegWrite_o && (ex_rs_hit || ex_rt_hit)) ||
                          (mem_MemRead_o && (mem_rs_hit || mem_rt_hit)));

  assign stall   = (HAZARD_EN != 0) && (load_use || branch_hazard);
  assign advance = !freeze_i && !stall;

  assign pc_write_o     = advance;
  assign ifid_write_o   = advance;
  assign branch_taken_o = advance && id_ctrl.branch && eq_i;
  assign jump_o         = advance && id_ctrl.jump;
  assign flush_o        = branch_taken_o || jump_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_RegDst_o    <= 1'b0;
      ex_ALUSrc_o    <= 1'b0;
      ex_ALUOp_o     <= '0;
      ex_dest_o      <= '0;
      ex_RegWrite_o  <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      mem_MemRead_o  <= 1'b0;
      mem_MemWrite_o <= 1'b0;
      mem_RegWrite_o <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_dest_o     <= '0;
      wb_RegWrite_o  <= 1'b0;
      wb_MemtoReg_o  <= 1'b0;
      wb_dest_o      <= '0;
    end else if (!freeze_i) begin
      if (stall) begin
        ex_RegDst_o   <= CTRL_NOP.reg_dst;
        ex_ALUSrc_o   <= CTRL_NOP.alu_src;
        ex_ALUOp_o    <= ALUOP_W'(CTRL_NOP.alu_op);
        ex_dest_o     <= '0;
        ex_RegWrite_o <= CTRL_NOP.reg_write;
        ex_mem_read   <= CTRL_NOP.mem_read;
        ex_mem_write  <= CTRL_NOP.mem_write;
        ex_mem_to_reg <= CTRL_NOP.mem_to_reg;
      end else begin
        ex_RegDst_o   <= id_ctrl.reg_dst;
        ex_ALUSrc_o   <= id_ctrl.alu_src;
        ex_ALUOp_o    <= ALUOP_W'(id_ctrl.alu_op);
        ex_dest_o     <= id_dest;
        ex_RegWrite_o <= id_ctrl.reg_write;
        ex_mem_read   <= id_ctrl.mem_read;
        ex_mem_write  <= id_ctrl.mem_write;
        ex_mem_to_reg <= id_ctrl.mem_to_reg;
      end
      mem_MemRead_o  <= ex_mem_read;
      mem_MemWrite_o <= ex_mem_write;
      mem_RegWrite_o <= ex_RegWrite_o;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_dest_o     <= ex_dest_o;
      wb_RegWrite_o  <= mem_RegWrite_o;
      wb_MemtoReg_o  <= mem_mem_to_reg;
      wb_dest_o      <= mem_dest_o;
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - directed vector table, async reset sequence and random run against a reference model
module tb_pipe_control;

  localparam logic [5:0] R_T = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0, rst = 1'b1, freeze = 1'b0, eq = 1'b0;
  logic [5:0] op = R_T;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       pc_write, ifid_write, flush, jump, branch_taken, illegal;
  logic       ex_regdst, ex_alusrc, ex_rw, mem_mr, mem_mw, mem_rw, wb_rw, wb_m2r;
  logic [1:0] ex_aluop;
  logic [4:0] ex_dest, mem_dest, wb_dest;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipe_control dut (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .Op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .eq_i(eq), .pc_write_o(pc_write), .ifid_write_o(ifid_write), .flush_o(flush),
    .jump_o(jump), .branch_taken_o(branch_taken), .illegal_o(illegal),
    .ex_RegDst_o(ex_regdst), .ex_ALUSrc_o(ex_alusrc), .ex_ALUOp_o(ex_aluop),
    .ex_dest_o(ex_dest), .ex_RegWrite_o(ex_rw), .mem_MemRead_o(mem_mr),
    .mem_MemWrite_o(mem_mw), .mem_RegWrite_o(mem_rw), .mem_dest_o(mem_dest),
    .wb_RegWrite_o(wb_rw), .wb_MemtoReg_o(wb_m2r), .wb_dest_o(wb_dest)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction's controls come from the opcode table; the
  // pipeline is a queue of the last three instructions that entered EX.
  typedef struct {
    bit known, reg_dst, alu_src, m2r, rw, mr, mw, br, jp;
    int aop;
  } dec_t;

  typedef struct {
    bit reg_dst, alu_src, m2r, rw, mr, mw;
    int aop, dest;
  } inst_t;

  inst_t hist[$];

  function automatic dec_t spec_dec(logic [5:0] o);
    dec_t d = '{default: 0};
    d.known = 1;
    case (o)
      R_T:  begin d.reg_dst = 1; d.rw = 1; d.aop = 2; end
      ADDI: begin d.alu_src = 1; d.rw = 1; end
      LW:   begin d.alu_src = 1; d.m2r = 1; d.rw = 1; d.mr = 1; end
      SW:   begin d.alu_src = 1; d.mw = 1; end
      BEQ:  begin d.br = 1; d.aop = 1; end
      JMP:  d.jp = 1;
      default: d.known = 0;
    endcase
    return d;
  endfunction

  function automatic bit hits(int d, int r);
    return d != 0 && d == r;
  endfunction

  function automatic bit model_stall();
    dec_t d = spec_dec(op);
    bit uses_rt = (op == R_T) || (op == BEQ) || (op == SW);
    bit lu = hist[0].mr && (hits(hist[0].dest, rs) || (uses_rt && hits(hist[0].dest, rt)));
    bit bh = d.br && ((hist[0].rw && (hits(hist[0].dest, rs) || hits(hist[0].dest, rt))) ||
                      (hist[1].mr && (hits(hist[1].dest, rs) || hits(hist[1].dest, rt))));
    return lu || bh;
  endfunction

  task automatic model_reset();
    inst_t z = '{default: 0};
    hist = {z, z, z};
  endtask

  task automatic model_check();
    dec_t d = spec_dec(op);
    bit go = !freeze && !model_stall();
    chk("pc_write", pc_write, go);
    chk("ifid_write", ifid_write, go);
    chk("branch_taken", branch_taken, go && d.br && eq);
    chk("jump", jump, go && d.jp);
    chk("flush", flush, go && ((d.br && eq) || d.jp));
    chk("illegal", illegal, !d.known);
    chk("ex_RegDst", ex_regdst, hist[0].reg_dst);
    chk("ex_ALUSrc", ex_alusrc, hist[0].alu_src);
    chk("ex_ALUOp", ex_aluop, hist[0].aop);
    chk("ex_RegWrite", ex_rw, hist[0].rw);
    chk("ex_dest", ex_dest, hist[0].dest);
    chk("mem_MemRead", mem_mr, hist[1].mr);
    chk("mem_MemWrite", mem_mw, hist[1].mw);
    chk("mem_RegWrite", mem_rw, hist[1].rw);
    chk("mem_dest", mem_dest, hist[1].dest);
    chk("wb_RegWrite", wb_rw, hist[2].rw);
    chk("wb_MemtoReg", wb_m2r, hist[2].m2r);
    chk("wb_dest", wb_dest, hist[2].dest);
  endtask

  task automatic model_clock();
    dec_t d = spec_dec(op);
    inst_t n = '{default: 0};
    if (freeze) return;
    if (!model_stall()) begin
      n.reg_dst = d.reg_dst; n.alu_src = d.alu_src; n.m2r = d.m2r;
      n.rw = d.rw; n.mr = d.mr; n.mw = d.mw; n.aop = d.aop;
      n.dest = !d.rw ? 0 : (d.reg_dst ? int'(rd) : int'(rt));
    end
    hist.push_front(n);
    void'(hist.pop_back());
  endtask

  // Inputs are driven just after the falling edge, sampled 1 ns later
  task automatic drive(input logic [5:0] o, input int s, t, r, input bit e, f);
    op = o; rs = s[4:0]; rt = t[4:0]; rd = r[4:0]; eq = e; freeze = f;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] op;
    int rs, rt, rd;
    bit eq, frz;
    bit pcw, fl, jp, bt, ill, ex_rw, ex_mr;
    int ex_d;
    bit mem_rw;
    int mem_d;
    bit wb_rw;
    int wb_d;
  } vec_t;

  vec_t tbl[21];

  initial begin
    //           op    rs rt rd eq fz pcw fl jp bt il exrw exmr exd mrw md wrw wd
    tbl[0]  = '{ADDI,  0, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0};
    tbl[1]  = '{R_T,   1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 9,  0, 0,  0, 0};
    tbl[2]  = '{LW,    0, 8, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 3,  1, 9,  0, 0};
    tbl[3]  = '{R_T,   8, 4, 10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8,  1, 3,  1, 9};
    tbl[4]  = '{R_T,   8, 4, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 8,  1, 3};
    tbl[5]  = '{BEQ,  10, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 10, 0, 0,  1, 8};
    tbl[6]  = '{BEQ,  10, 8, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0,  1, 10, 0, 0};
    tbl[7]  = '{LW,    0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  1, 10};
    tbl[8]  = '{BEQ,   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5,  0, 0,  0, 0};
    tbl[9]  = '{BEQ,   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 5,  0, 0};
    tbl[10] = '{BEQ,   5, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0,  0, 0,  1, 5};
    tbl[11] = '{JMP,   0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0,  0, 0};
    tbl[12] = '{BAD,   0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0,  0, 0,  0, 0};
    tbl[13] = '{LW,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0};
    tbl[14] = '{R_T,   0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0,  0, 0};
    tbl[15] = '{ADDI,  7, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 7,  1, 0,  0, 0};
    tbl[16] = '{ADDI,  7, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 7,  1, 0,  0, 0};
    tbl[17] = '{ADDI,  7, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 7,  1, 0,  0, 0};
    tbl[18] = '{ADDI,  7, 6, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7,  1, 0,  0, 0};
    tbl[19] = '{BEQ,   6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 6,  1, 7,  1, 0};
    tbl[20] = '{BEQ,   6, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 6,  1, 7};

    model_reset();
    @(negedge clk);
    drive(R_T, 0, 0, 0, 0, 0);
    chk("reset pc_write", pc_write, 1);
    chk("reset ifid_write", ifid_write, 1);
    chk("reset ex_RegWrite", ex_rw, 0);
    chk("reset wb_dest", wb_dest, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].eq, tbl[i].frz);
      chk($sformatf("v%0d pc_write", i), pc_write, tbl[i].pcw);
      chk($sformatf("v%0d flush", i), flush, tbl[i].fl);
      chk($sformatf("v%0d jump", i), jump, tbl[i].jp);
      chk($sformatf("v%0d branch_taken", i), branch_taken, tbl[i].bt);
      chk($sformatf("v%0d illegal", i), illegal, tbl[i].ill);
      chk($sformatf("v%0d ex_RegWrite", i), ex_rw, tbl[i].ex_rw);
      chk($sformatf("v%0d ex_MemRead", i), dut.ex_mem_read, tbl[i].ex_mr);
      chk($sformatf("v%0d ex_dest", i), ex_dest, tbl[i].ex_d);
      chk($sformatf("v%0d mem_RegWrite", i), mem_rw, tbl[i].mem_rw);
      chk($sformatf("v%0d mem_dest", i), mem_dest, tbl[i].mem_d);
      chk($sformatf("v%0d wb_RegWrite", i), wb_rw, tbl[i].wb_rw);
      chk($sformatf("v%0d wb_dest", i), wb_dest, tbl[i].wb_d);
      model_check();
      finish_cycle();
    end

    // Asynchronous reset landing in the middle of a load-use stall
    drive(LW, 0, 8, 0, 0, 0);
    model_check();
    finish_cycle();
    drive(R_T, 8, 3, 4, 0, 0);
    chk("pre-reset stall pc_write", pc_write, 0);
    rst = 1'b1;
    #1;
    chk("async rst ex_RegWrite", ex_rw, 0);
    chk("async rst ex_dest", ex_dest, 0);
    chk("async rst mem_RegWrite", mem_rw, 0);
    chk("async rst mem_dest", mem_dest, 0);
    chk("async rst wb_RegWrite", wb_rw, 0);
    chk("async rst pc_write", pc_write, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic [5:0] pick [7];
      pick = '{R_T, ADDI, LW, SW, BEQ, JMP, 6'($urandom)};
      drive(pick[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 7) == 0);
      model_check();
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
